isa_cycle_ctrl: RTL
===================

ISA_CYCLE_CTRL -- requirements
Module: isa_cycle_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- SETUP_CYC, 4, address/data setup cycles before strobe (>=1)
- STROBE_CYC, 6, minimum strobe-low cycles (>=1)
- HOLD_CYC, 2, address/data hold cycles after strobe (>=1)
- TIMEOUT_CYC, 255, maximum IOCHRDY wait cycles (>=1, <=255)
REQ-002 SHALL have one clock, clk, and a synchronous active-high reset, reset; no other clock or reset.
REQ-003 SHALL have these ports, one per line:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous active-high reset
- req  in  1  start-cycle request, level, sampled only in IDLE
- read  in  1  1 = I/O read, 0 = I/O write, sampled with req
- addr  in  16  I/O address, sampled with req
- wdata  in  16  write data, sampled with req
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid from the ack cycle until the next accept
- timeout_err  out  1  last cycle timed out, valid with ack
- isa_addr  out  16  latched address to the ISA bus
- isa_dout  out  16  latched write data
- isa_doe  out  1  data output enable, writes only
- isa_din  in  16  ISA data bus input
- IOCHRDY  in  1  1 = ready, 0 = insert wait states
- nIOR  out  1  active-low I/O read strobe
- nIOW  out  1  active-low I/O write strobe

Function
REQ-004 SHALL drive every output from a register; there SHALL be no combinational path from an input to an output.
REQ-005 SHALL implement the FSM states IDLE, SETUP, STROBE, WAIT, HOLD and DONE.
REQ-006 IDLE: when req=1, SHALL latch read, addr and wdata and go to SETUP; when req=0, SHALL stay in IDLE.
REQ-007 SHALL ignore req in every state other than IDLE; a request arriving while busy is not queued.
REQ-008 SETUP: SHALL last exactly SETUP_CYC cycles; isa_addr valid; for writes, isa_doe=1 and isa_dout=wdata; both strobes high; then go to STROBE.
REQ-009 STROBE: SHALL hold nIOR=0 (read) or nIOW=0 (write) for exactly STROBE_CYC cycles.
REQ-010 In the last STROBE cycle, SHALL sample IOCHRDY: 1 -> go to HOLD; 0 -> go to WAIT.
REQ-011 WAIT: the strobe SHALL stay low; IOCHRDY SHALL be sampled each cycle; when IOCHRDY=1, go to HOLD.
REQ-012 If WAIT reaches TIMEOUT_CYC cycles with IOCHRDY still 0, SHALL set timeout_err=1, force rdata=16'hFFFF and go to HOLD.
REQ-013 For reads, SHALL capture isa_din into rdata on the edge that leaves STROBE or WAIT for HOLD, except on timeout.
REQ-014 HOLD: both strobes high; isa_addr held; isa_doe held for writes; SHALL last HOLD_CYC cycles, then go to DONE.
REQ-015 DONE: SHALL assert ack=1 for exactly one cycle, then go to IDLE; timeout_err SHALL hold its value until the next accept clears it.
REQ-016 Latency without wait states: ack SHALL be high SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after the accepting edge (13 with defaults).
REQ-017 Each wait cycle SHALL add exactly one cycle to the latency.
REQ-018 If req is still high in the IDLE cycle after DONE, a new cycle SHALL start with no extra dead cycle.
REQ-019 nIOR and nIOW SHALL never both be low, and neither SHALL be low outside STROBE/WAIT.
REQ-020 isa_doe SHALL be 0 for reads in every state.
REQ-021 The SETUP/STROBE/HOLD counters SHALL be 8 bits and the wait counter 8 bits; none SHALL wrap.

Reset
REQ-022 While reset=1, SHALL force: state IDLE, nIOR=1, nIOW=1, isa_doe=0, busy=0, ack=0, timeout_err=0, rdata=0, isa_addr=0, isa_dout=0, all counters 0.
REQ-023 Reset asserted mid-cycle SHALL abort the cycle at the next edge: strobes high, no ack and no hold phase.
REQ-024 reset SHALL take priority over req.

Verification
REQ-025 Read 0x0300, IOCHRDY=1, isa_din=0x1234 -> nIOR low for exactly 6 cycles, no nIOW, ack at cycle 13, rdata=0x1234, timeout_err=0.
REQ-026 Write 0x0301 with data 0xA5A5 -> isa_doe=1 for 12 cycles, nIOW low for 6, isa_dout=0xA5A5, ack at cycle 13.
REQ-027 Read with IOCHRDY low for 10 cycles from the end of STROBE -> strobe low for 16 cycles, ack at cycle 23, correct rdata.
REQ-028 Read with IOCHRDY held at 0 -> timeout after 255 WAIT cycles, rdata=0xFFFF, timeout_err=1 with ack, strobe released.
REQ-029 req held high continuously -> back-to-back cycles with ack every 14 cycles; req pulses while busy -> ignored.
REQ-030 reset pulsed during STROBE -> strobes high and busy=0 at the next edge, no ack, next req runs a normal cycle.

Source files
------------

// File: rtl/isa_cycle_ctrl.sv
// ISA I/O bus cycle controller: sequences setup, strobe, IOCHRDY wait states
// and hold around a single host request, with a bounded wait timeout.
module isa_cycle_ctrl #(
  parameter int SETUP_CYC   = 4,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        read,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        timeout_err,
  output logic [15:0] isa_addr,
  output logic [15:0] isa_dout,
  output logic        isa_doe,
  input  logic [15:0] isa_din,
  input  logic        IOCHRDY,
  output logic        nIOR,
  output logic        nIOW
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Counters run 0..N-1, so compare against the last index of each phase.
  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_r;
  logic [7:0]  phase_cnt_r;
  logic [7:0]  wait_cnt_r;
  logic        rd_r;

  // Bus-cycle sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      phase_cnt_r <= 8'd0;
      wait_cnt_r  <= 8'd0;
      rd_r        <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      rdata       <= 16'h0000;
      timeout_err <= 1'b0;
      isa_addr    <= 16'h0000;
      isa_dout    <= 16'h0000;
      isa_doe     <= 1'b0;
      nIOR        <= 1'b1;
      nIOW        <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            rd_r        <= read;
            isa_addr    <= addr;
            isa_dout    <= wdata;
            isa_doe     <= ~read;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            phase_cnt_r <= 8'd0;
            wait_cnt_r  <= 8'd0;
            state_r     <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end

        SETUP: begin
          if (phase_cnt_r == SETUP_LAST) begin
            phase_cnt_r <= 8'd0;
            nIOR        <= ~rd_r;
            nIOW        <= rd_r;
            state_r     <= STROBE;
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end

        STROBE: begin
          if (phase_cnt_r == STROBE_LAST) begin
            phase_cnt_r <= 8'd0;
            wait_cnt_r  <= 8'd0;
            if (IOCHRDY) begin
              nIOR    <= 1'b1;
              nIOW    <= 1'b1;
              state_r <= HOLD;
              if (rd_r) begin
                rdata <= isa_din;
              end else begin
                rdata <= rdata;
              end
            end else begin
              state_r <= WAIT;
            end
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end

        WAIT: begin
          // Strobe stays low here; release it on ready or on timeout.
          if (IOCHRDY) begin
            nIOR    <= 1'b1;
            nIOW    <= 1'b1;
            state_r <= HOLD;
            if (rd_r) begin
              rdata <= isa_din;
            end else begin
              rdata <= rdata;
            end
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            nIOR        <= 1'b1;
            nIOW        <= 1'b1;
            timeout_err <= 1'b1;
            rdata       <= 16'hFFFF;
            state_r     <= HOLD;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end

        HOLD: begin
          if (phase_cnt_r == HOLD_LAST) begin
            phase_cnt_r <= 8'd0;
            isa_doe     <= 1'b0;
            ack         <= 1'b1;
            state_r     <= DONE;
          end else begin
            phase_cnt_r <= phase_cnt_r + 8'd1;
          end
        end

        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          busy        <= 1'b0;
          isa_doe     <= 1'b0;
          nIOR        <= 1'b1;
          nIOW        <= 1'b1;
          phase_cnt_r <= 8'd0;
          wait_cnt_r  <= 8'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
